// File: rtl/exec_unit_if.sv
// Issue/result handshake bundle for the execute stage.
// master = upstream/downstream side, slave = exec_unit.
interface exec_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [16:0]     op_in;
  logic [XLEN-1:0] d1_in;
  logic [XLEN-1:0] d2_in;
  logic [XLEN-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch;
  logic            jalr;

  modport master (output in_valid, op_in, d1_in, d2_in, pc_in, out_ready,
                  input  in_ready, out_valid, result, branch, jalr);
  modport slave  (input  in_valid, op_in, d1_in, d2_in, pc_in, out_ready,
                  output in_ready, out_valid, result, branch, jalr);
endinterface

// File: rtl/exec_unit.sv
// RV32I execute stage with registered result/branch/jalr behind a valid/ready handshake.
// Define EXEC_UNIT_MULDIV_EN to add the iterative RV32M multiply/divide (XLEN busy cycles).
module exec_unit #(
  parameter int XLEN = 32
) (
  input  logic     clock,
  input  logic     reset,
  exec_unit_if.slave bus
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [6:0] OPC_OP  = 7'b0110011, OPC_IMM = 7'b0010011,
                         OPC_LD  = 7'b0000011, OPC_ST  = 7'b0100011,
                         OPC_BR  = 7'b1100011, OPC_JAL = 7'b1101111,
                         OPC_JR  = 7'b1100111, OPC_LUI = 7'b0110111,
                         OPC_AUI = 7'b0010111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            br;
    logic            jr;
  } rsp_t;

  state_t          state, nxt;
  rsp_t            rsp, out_q;
  logic            acc, is_md, md_last, alt, lts, ltu, eq;
  logic [XLEN-1:0] alu;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] d1, d2, pc;
  logic [SHAMT_W-1:0] sh;

  assign opc = bus.op_in[6:0];
  assign f3  = bus.op_in[9:7];
  assign f7  = bus.op_in[16:10];
  assign d1  = bus.d1_in;
  assign d2  = bus.d2_in;
  assign pc  = bus.pc_in;
  assign sh  = d2[SHAMT_W-1:0];

  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = out_q.res;
  assign bus.branch    = out_q.br;
  assign bus.jalr      = out_q.jr;
  assign acc           = bus.in_valid & bus.in_ready;

  // Single-cycle decode; anything not recognised leaves rsp at zero.
  always_comb begin
    rsp = '0;
    lts = $signed(d1) < $signed(d2);
    ltu = d1 < d2;
    eq  = d1 == d2;
    alt = (opc == OPC_OP) ? (f7 == 7'b0100000) : ((f3 == 3'b101) && d2[10]);
    case (f3)
      3'b000:  alu = alt ? d1 - d2 : d1 + d2;
      3'b001:  alu = d1 << sh;
      3'b010:  alu = {{(XLEN-1){1'b0}}, lts};
      3'b011:  alu = {{(XLEN-1){1'b0}}, ltu};
      3'b100:  alu = d1 ^ d2;
      3'b101:  alu = alt ? XLEN'($signed(d1) >>> sh) : d1 >> sh;
      3'b110:  alu = d1 | d2;
      default: alu = d1 & d2;
    endcase
    case (opc)
      OPC_OP:  if (f7 == 7'b0 || (alt && (f3 == 3'b000 || f3 == 3'b101))) rsp.res = alu;
      OPC_IMM: rsp.res = alu;
      OPC_LD, OPC_ST: rsp.res = d1 + d2;
      OPC_BR: begin
        case (f3)
          3'b000:  rsp.br = eq;
          3'b001:  rsp.br = !eq;
          3'b100:  rsp.br = lts;
          3'b101:  rsp.br = !lts;
          3'b110:  rsp.br = ltu;
          3'b111:  rsp.br = !ltu;
          default: rsp.br = 1'b0;
        endcase
      end
      OPC_JAL: begin rsp.res = pc + XLEN'(4); rsp.br = 1'b1; end
      OPC_JR:  begin rsp.res = pc + XLEN'(4); rsp.br = 1'b1; rsp.jr = 1'b1; end
      OPC_LUI: rsp.res = d2 << 12;
      OPC_AUI: rsp.res = pc + (d2 << 12);
      default: ;
    endcase
  end

`ifdef EXEC_UNIT_MULDIV_EN
  localparam int CNT_W = $clog2(XLEN);
  logic [XLEN-1:0]   md_b, hi, lo, hi_n, lo_n, md_res, a_mag, b_mag;
  logic [XLEN:0]     sum, r_sh, trial;
  logic [2*XLEN-1:0] prod;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        md_f3;
  logic              md_neg, md_rneg, md_dz, a_sgn, b_sgn, a_neg, b_neg;

  assign is_md   = (opc == OPC_OP) && (f7 == 7'b0000001);
  assign md_last = (state == BUSY) && (cnt == CNT_W'(XLEN-1));

  // {hi,lo} is shared: shift-right product for mul, shift-left rem/quotient for div.
  always_comb begin
    a_sgn = !(f3 inside {3'b011, 3'b101, 3'b111});
    b_sgn = a_sgn && (f3 != 3'b010);
    a_neg = a_sgn & d1[XLEN-1];
    b_neg = b_sgn & d2[XLEN-1];
    a_mag = a_neg ? -d1 : d1;
    b_mag = b_neg ? -d2 : d2;
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, md_b} : '0);
    r_sh  = {hi, lo[XLEN-1]};
    trial = r_sh - {1'b0, md_b};
    if (md_f3[2]) begin
      if (!trial[XLEN]) begin hi_n = trial[XLEN-1:0]; lo_n = {lo[XLEN-2:0], 1'b1}; end
      else              begin hi_n = r_sh[XLEN-1:0];  lo_n = {lo[XLEN-2:0], 1'b0}; end
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
    prod = {hi_n, lo_n};
    if (md_neg) prod = -prod;
    case (md_f3)
      3'b000:                md_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        md_res = md_dz ? '1 : (md_neg ? -lo_n : lo_n);
      default:               md_res = md_rneg ? -hi_n : hi_n;
    endcase
  end

  always_ff @(posedge clock) begin
    if (acc && is_md) begin
      md_f3   <= f3;
      md_neg  <= a_neg ^ b_neg;
      md_rneg <= a_neg;
      md_dz   <= (d2 == '0);
      cnt     <= '0;
      hi      <= '0;
      md_b    <= f3[2] ? b_mag : a_mag;
      lo      <= f3[2] ? a_mag : b_mag;
    end else if (state == BUSY) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign is_md   = 1'b0;
  assign md_last = 1'b1;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (acc) nxt = is_md ? BUSY : DONE;
      BUSY:    if (md_last) nxt = DONE;
      DONE:    if (acc) nxt = is_md ? BUSY : DONE;
               else if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      out_q <= '0;
    end else begin
      state <= nxt;
      if (acc && !is_md) out_q <= rsp;
`ifdef EXEC_UNIT_MULDIV_EN
      else if (md_last) out_q <= '{res: md_res, br: 1'b0, jr: 1'b0};
`endif
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Directed table-driven bench for exec_unit plus back-pressure and reset sequences.
module tb_exec_unit;
  localparam logic [6:0] OP = 7'b0110011, IMM = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JR = 7'b1100111, LUI = 7'b0110111, AUI = 7'b0010111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_unit_if #(.XLEN(32)) bus();
  exec_unit #(.XLEN(32)) dut (.clock(clk), .reset(rst), .bus(bus.slave));

  int errs = 0;
  int checks = 0;

  typedef struct {
    string       nm;
    logic [16:0] op;
    logic [31:0] d1, d2, pc, res;
    logic        br, jr;
    int          lat;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] d1, d2, pc, res,
                     input logic br, jr, input int lat);
    vec_t v;
    v.nm = nm; v.op = {f7, f3, opc}; v.d1 = d1; v.d2 = d2; v.pc = pc;
    v.res = res; v.br = br; v.jr = jr; v.lat = lat;
    vq.push_back(v);
  endtask

  // Issue one op with out_ready high; lat counts edges from accept (inclusive) to out_valid.
  task automatic run_op(input logic [16:0] op, input logic [31:0] d1, d2, pc,
                        output logic [31:0] res, output logic br, jr, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    bus.op_in = op; bus.d1_in = d1; bus.d2_in = d2; bus.pc_in = pc;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    while (!bus.in_ready && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
    res = bus.result; br = bus.branch; jr = bus.jalr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic b, j;
    int l, seen;

    add("addi",    IMM, 3'b000, 7'h00, 32'd5,        32'hFFFFFFFD, 0, 32'd2,        0, 0, 1);
    add("sub",     OP,  3'b000, 7'h20, 32'd3,        32'd5,        0, 32'hFFFFFFFE, 0, 0, 1);
    add("add_wrap",OP,  3'b000, 7'h00, 32'hFFFFFFFF, 32'd1,        0, 32'h0,        0, 0, 1);
    add("slt",     OP,  3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        0, 32'd1,        0, 0, 1);
    add("sltu",    OP,  3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        0, 32'd0,        0, 0, 1);
    add("slti",    IMM, 3'b010, 7'h00, 32'h80000000, 32'd0,        0, 32'd1,        0, 0, 1);
    add("sltiu",   IMM, 3'b011, 7'h00, 32'h80000000, 32'd0,        0, 32'd0,        0, 0, 1);
    add("sra",     OP,  3'b101, 7'h20, 32'h80000000, 32'd4,        0, 32'hF8000000, 0, 0, 1);
    add("srl",     OP,  3'b101, 7'h00, 32'h80000000, 32'd4,        0, 32'h08000000, 0, 0, 1);
    add("srai",    IMM, 3'b101, 7'h20, 32'h80000000, 32'h404,      0, 32'hF8000000, 0, 0, 1);
    add("srli",    IMM, 3'b101, 7'h00, 32'h80000000, 32'd4,        0, 32'h08000000, 0, 0, 1);
    add("sll_amt", OP,  3'b001, 7'h00, 32'd1,        32'h21,       0, 32'd2,        0, 0, 1);
    add("xor",     OP,  3'b100, 7'h00, 32'hA5A5A5A5, 32'hFFFF0000, 0, 32'h5A5AA5A5, 0, 0, 1);
    add("or",      OP,  3'b110, 7'h00, 32'h0F0,      32'h00F,      0, 32'h0FF,      0, 0, 1);
    add("and",     OP,  3'b111, 7'h00, 32'h0FF,      32'h0F0,      0, 32'h0F0,      0, 0, 1);
    add("blt",     BR,  3'b100, 7'h00, 32'hFFFFFFFF, 32'd0,        0, 32'd0,        1, 0, 1);
    add("bltu",    BR,  3'b110, 7'h00, 32'hFFFFFFFF, 32'd0,        0, 32'd0,        0, 0, 1);
    add("bge",     BR,  3'b101, 7'h00, 32'hFFFFFFFF, 32'd0,        0, 32'd0,        0, 0, 1);
    add("bgeu",    BR,  3'b111, 7'h00, 32'hFFFFFFFF, 32'd0,        0, 32'd0,        1, 0, 1);
    add("beq",     BR,  3'b000, 7'h00, 32'd7,        32'd7,        0, 32'd0,        1, 0, 1);
    add("bne",     BR,  3'b001, 7'h00, 32'd7,        32'd7,        0, 32'd0,        0, 0, 1);
    add("br_rsv2", BR,  3'b010, 7'h00, 32'd7,        32'd7,        0, 32'd0,        0, 0, 1);
    add("br_rsv3", BR,  3'b011, 7'h00, 32'd1,        32'd2,        0, 32'd0,        0, 0, 1);
    add("jal",     JAL, 3'b000, 7'h00, 32'd0,        32'd0,   32'h200, 32'h204,     1, 0, 1);
    add("jalr",    JR,  3'b000, 7'h00, 32'h40,       32'd0,   32'h100, 32'h104,     1, 1, 1);
    add("lui",     LUI, 3'b000, 7'h00, 32'd0,        32'h12345,    0, 32'h12345000, 0, 0, 1);
    add("auipc",   AUI, 3'b000, 7'h00, 32'd0,        32'd1,  32'h1000, 32'h2000,    0, 0, 1);
    add("load",    LD,  3'b010, 7'h00, 32'hFFFFFFFC, 32'd8,        0, 32'd4,        0, 0, 1);
    add("store",   ST,  3'b010, 7'h00, 32'h100,      32'hFFFFFFFC, 0, 32'hFC,       0, 0, 1);
    add("bad_opc", 7'h7F, 3'b000, 7'h00, 32'd1,      32'd1,        0, 32'd0,        0, 0, 1);
    add("bad_f7",  OP,  3'b001, 7'h20, 32'd1,        32'd1,        0, 32'd0,        0, 0, 1);
`ifdef EXEC_UNIT_MULDIV_EN
    add("mul",     OP,  3'b000, 7'h01, 32'd3,        32'd4,        0, 32'd12,       0, 0, 33);
    add("mulh",    OP,  3'b001, 7'h01, 32'h80000000, 32'd2,        0, 32'hFFFFFFFF, 0, 0, 33);
    add("mulhsu",  OP,  3'b010, 7'h01, 32'hFFFFFFFF, 32'd2,        0, 32'hFFFFFFFF, 0, 0, 33);
    add("mulhu",   OP,  3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 0, 0, 33);
    add("div_z",   OP,  3'b100, 7'h01, 32'd7,        32'd0,        0, 32'hFFFFFFFF, 0, 0, 33);
    add("rem_z",   OP,  3'b110, 7'h01, 32'd7,        32'd0,        0, 32'd7,        0, 0, 33);
    add("div_ovf", OP,  3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 0, 33);
    add("rem_ovf", OP,  3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0,        0, 0, 33);
    add("div_neg", OP,  3'b100, 7'h01, 32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFD, 0, 0, 33);
    add("rem_neg", OP,  3'b110, 7'h01, 32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFF, 0, 0, 33);
    add("divu",    OP,  3'b101, 7'h01, 32'd100,      32'd7,        0, 32'd14,       0, 0, 33);
    add("remu",    OP,  3'b111, 7'h01, 32'd100,      32'd7,        0, 32'd2,        0, 0, 33);
`else
    add("mul_off", OP,  3'b000, 7'h01, 32'd3,        32'd4,        0, 32'd0,        0, 0, 1);
`endif

    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op_in = '0;
    bus.d1_in = '0; bus.d2_in = '0; bus.pc_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst.result",    bus.result,         32'd0);
    chk("rst.branch",    32'(bus.branch),    32'd0);
    chk("rst.jalr",      32'(bus.jalr),      32'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      run_op(vq[i].op, vq[i].d1, vq[i].d2, vq[i].pc, r, b, j, l);
      chk({vq[i].nm, ".res"}, r,      vq[i].res);
      chk({vq[i].nm, ".br"},  32'(b), 32'(vq[i].br));
      chk({vq[i].nm, ".jr"},  32'(j), 32'(vq[i].jr));
      chk({vq[i].nm, ".lat"}, 32'(l), 32'(vq[i].lat));
    end

    // Back-pressure: jalr held for 3 cycles while a sub waits, then both move on one edge.
    @(negedge clk);
    bus.op_in = {7'h00, 3'b000, JR}; bus.d1_in = 0; bus.d2_in = 0; bus.pc_in = 32'h300;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.op_in = {7'h20, 3'b000, OP}; bus.d1_in = 32'd50; bus.d2_in = 32'd8;
    for (int k = 0; k < 3; k++) begin
      chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.result",    bus.result,         32'h304);
      chk("bp.branch",    32'(bus.branch),    32'd1);
      chk("bp.jalr",      32'(bus.jalr),      32'd1);
      chk("bp.in_ready",  32'(bus.in_ready),  32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp.next_valid",  32'(bus.out_valid), 32'd1);
    chk("bp.next_result", bus.result,         32'd42);
    chk("bp.next_jalr",   32'(bus.jalr),      32'd0);
    @(negedge clk);
    chk("bp.drain", 32'(bus.out_valid), 32'd0);

    // Reset while a result is waiting in DONE.
    bus.op_in = {7'h00, 3'b000, OP}; bus.d1_in = 32'd9; bus.d2_in = 32'd9;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rd.result", bus.result, 32'd18);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rd.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rd.result0",   bus.result,         32'd0);
    chk("rd.in_ready",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;

`ifdef EXEC_UNIT_MULDIV_EN
    // Reset on the 10th busy cycle of a divide: no result may ever appear.
    @(negedge clk);
    bus.op_in = {7'h01, 3'b100, OP}; bus.d1_in = 32'd100; bus.d2_in = 32'd7;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rb.busy_ready", 32'(bus.in_ready), 32'd0);
    repeat (9) @(negedge clk);
    chk("rb.busy_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rb.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rb.in_ready",  32'(bus.in_ready),  32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("rb.no_result", 32'(seen), 32'd0);
`else
    seen = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
